branch_predict_ctrl: RTL and testbench

Controller that sequences the branch predictor tables and resolves predictions in Execute. After reset it walks every table index to clear BHT/PHT/BTB state, holding Fetch stalled. It then compares the prediction carried down the pipe with the actual outcome in Execute. From that comparison it generates the predictor update strobes (`Branch_mispredict`, `BTA_mispredict`), the PC redirect and the pipeline flushes, and it keeps mispredict statistics. It sits between the Execute stage, the hazard unit and the predictor.

---
 rtl/branch_predict_ctrl.sv | 139 +++++++++++++
 tb/tb_branch_predict_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Branch predictor controller: clears the predictor tables after reset,
// then resolves carried predictions in Execute and drives updates/redirects.
module branch_predict_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  PredEn,
    input  logic                  BranchE,
    input  logic                  StallE,
    input  logic [31:0]           PCE,
    input  logic                  PCSrcE,
    input  logic [31:0]           ALUResultE,
    input  logic                  PrPCSrcE,
    input  logic [31:0]           PrALUResultE,
    input  logic                  PrPCSrcF_in,
    output logic                  PrPCSrcF,
    output logic                  ClrEn,
    output logic [ADDR_WIDTH-1:0] ClrIdx,
    output logic                  InitBusy,
    output logic                  Branch_mispredict,
    output logic                  BTA_mispredict,
    output logic                  Redirect,
    output logic [31:0]           RedirectPC,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [CNT_WIDTH-1:0]  BranchCnt,
    output logic [CNT_WIDTH-1:0]  MissCnt
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] idx_nxt;
    logic                  resolved;
    logic                  run;
    logic                  eligible;
    logic                  tgt_diff;
    logic                  dir_miss;
    logic                  tgt_miss;
    logic                  any_miss;

    // State and sweep-index register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Sweep every table index once, then stay in RUN until reset
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ClrEn     = 1'b0;
        InitBusy  = 1'b0;
        unique case (state)
            INIT: begin
                ClrEn    = 1'b1;
                InitBusy = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = RUN;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign ClrIdx = idx;

    // Resolution: compare the carried prediction with the real outcome
    always_comb begin
        run      = (state == RUN);
        eligible = run & BranchE & ~resolved;
        tgt_diff = (PrALUResultE != ALUResultE);
        dir_miss = eligible & (PrPCSrcE != PCSrcE);
        tgt_miss = eligible & PCSrcE & PrPCSrcE & tgt_diff;
        any_miss = dir_miss | tgt_miss;
    end

    assign Branch_mispredict = dir_miss;
    assign BTA_mispredict    = eligible & PCSrcE & tgt_diff;
    assign Redirect          = any_miss;
    assign FlushD            = any_miss;
    assign FlushE            = any_miss;

    // Corrected fetch address; held at zero while the tables are swept
    always_comb begin
        RedirectPC = 32'd0;
        if (run) begin
            RedirectPC = PCSrcE ? ALUResultE : (PCE + 32'd4);
        end
    end

    assign PrPCSrcF = PrPCSrcF_in & PredEn & ~InitBusy;

    // A branch held in Execute resolves only on its first cycle there
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            resolved <= 1'b0;
        end else if (!StallE) begin
            resolved <= 1'b0;
        end else if (eligible) begin
            resolved <= 1'b1;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            BranchCnt <= '0;
            MissCnt   <= '0;
        end else begin
            if (eligible && BranchCnt != CNT_MAX) begin
                BranchCnt <= BranchCnt + 1'b1;
            end
            if (any_miss && MissCnt != CNT_MAX) begin
                MissCnt <= MissCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_branch_predict_ctrl;

    logic        CLK;
    logic        RESETn;
    logic        PredEn;
    logic        BranchE;
    logic        StallE;
    logic [31:0] PCE;
    logic        PCSrcE;
    logic [31:0] ALUResultE;
    logic        PrPCSrcE;
    logic [31:0] PrALUResultE;
    logic        PrPCSrcF_in;

    logic        PrPCSrcF, ClrEn, InitBusy, BM, BTA, Redirect, FlushD, FlushE;
    logic [5:0]  ClrIdx;
    logic [31:0] RedirectPC;
    logic [15:0] BranchCnt, MissCnt;

    logic        PrPCSrcF4, ClrEn4, InitBusy4, BM4, BTA4, Redirect4, FlushD4, FlushE4;
    logic [5:0]  ClrIdx4;
    logic [31:0] RedirectPC4;
    logic [3:0]  BranchCnt4, MissCnt4;

    int npass = 0;
    int ntot  = 0;

    branch_predict_ctrl u_dut (
        .CLK(CLK), .RESETn(RESETn), .PredEn(PredEn), .BranchE(BranchE),
        .StallE(StallE), .PCE(PCE), .PCSrcE(PCSrcE), .ALUResultE(ALUResultE),
        .PrPCSrcE(PrPCSrcE), .PrALUResultE(PrALUResultE),
        .PrPCSrcF_in(PrPCSrcF_in), .PrPCSrcF(PrPCSrcF), .ClrEn(ClrEn),
        .ClrIdx(ClrIdx), .InitBusy(InitBusy), .Branch_mispredict(BM),
        .BTA_mispredict(BTA), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .FlushD(FlushD), .FlushE(FlushE), .BranchCnt(BranchCnt),
        .MissCnt(MissCnt)
    );

    branch_predict_ctrl #(.ADDR_WIDTH(6), .CNT_WIDTH(4)) u_dut4 (
        .CLK(CLK), .RESETn(RESETn), .PredEn(PredEn), .BranchE(BranchE),
        .StallE(StallE), .PCE(PCE), .PCSrcE(PCSrcE), .ALUResultE(ALUResultE),
        .PrPCSrcE(PrPCSrcE), .PrALUResultE(PrALUResultE),
        .PrPCSrcF_in(PrPCSrcF_in), .PrPCSrcF(PrPCSrcF4), .ClrEn(ClrEn4),
        .ClrIdx(ClrIdx4), .InitBusy(InitBusy4), .Branch_mispredict(BM4),
        .BTA_mispredict(BTA4), .Redirect(Redirect4), .RedirectPC(RedirectPC4),
        .FlushD(FlushD4), .FlushE(FlushE4), .BranchCnt(BranchCnt4),
        .MissCnt(MissCnt4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: cycles since reset, one-shot flag, plain int counts
    int m_cyc;
    bit m_res;
    int m_bc, m_mc, m_bc4, m_mc4;

    function automatic bit m_init();
        return m_cyc < 64;
    endfunction

    function automatic bit m_elig();
        return !m_init() && BranchE && !m_res;
    endfunction

    function automatic bit m_miss();
        bit wrong_dir;
        bit wrong_tgt;
        wrong_dir = (PCSrcE != PrPCSrcE);
        wrong_tgt = PCSrcE && PrPCSrcE && (ALUResultE != PrALUResultE);
        return m_elig() && (wrong_dir || wrong_tgt);
    endfunction

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            m_cyc = 0; m_res = 0;
            m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
        end else begin
            bit e, x;
            e = m_elig();
            x = m_miss();
            if (m_cyc < 64) m_cyc++;
            if (e) begin
                if (m_bc < 65535) m_bc++;
                if (m_bc4 < 15) m_bc4++;
            end
            if (x) begin
                if (m_mc < 65535) m_mc++;
                if (m_mc4 < 15) m_mc4++;
            end
            if (!StallE) m_res = 0;
            else if (e) m_res = 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        bit i, e, x, bta;
        logic [31:0] rpc;
        i   = m_init();
        e   = m_elig();
        x   = m_miss();
        bta = e && PCSrcE && (ALUResultE != PrALUResultE);
        rpc = i ? 32'd0 : (PCSrcE ? ALUResultE : PCE + 32'd4);
        chk("m_ClrEn", ClrEn, i);
        chk("m_InitBusy", InitBusy, i);
        if (i) chk("m_ClrIdx", ClrIdx, m_cyc);
        chk("m_PrPCSrcF", PrPCSrcF, PrPCSrcF_in && PredEn && !i);
        chk("m_BM", BM, e && (PCSrcE != PrPCSrcE));
        chk("m_BTA", BTA, bta);
        chk("m_Redirect", Redirect, x);
        chk("m_FlushD", FlushD, x);
        chk("m_FlushE", FlushE, x);
        if (i || x) chk("m_RedirectPC", RedirectPC, rpc);
        chk("m_BranchCnt", BranchCnt, m_bc);
        chk("m_MissCnt", MissCnt, m_mc);
        chk("m_BranchCnt4", BranchCnt4, m_bc4);
        chk("m_MissCnt4", MissCnt4, m_mc4);
        chk("m_Redirect4", Redirect4, x);
    end

    task automatic drv(input bit br, input bit st, input logic [31:0] pc,
                       input bit src, input logic [31:0] alu,
                       input bit psrc, input logic [31:0] palu);
        @(posedge CLK);
        #1;
        BranchE = br; StallE = st; PCE = pc; PCSrcE = src;
        ALUResultE = alu; PrPCSrcE = psrc; PrALUResultE = palu;
    endtask

    task automatic idle();
        drv(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic sweep_check(input string tag);
        int n;
        bit ok;
        n = 0;
        ok = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (!ClrEn) break;
            if (ClrIdx != n[5:0]) ok = 0;
            n++;
        end
        chk({tag, "_len"}, n, 64);
        chk({tag, "_idx_seq"}, {31'd0, ok}, 32'd1);
        chk({tag, "_busy_low"}, InitBusy, 1'b0);
    endtask

    initial begin
        RESETn = 0; PredEn = 1; PrPCSrcF_in = 0;
        BranchE = 0; StallE = 0; PCE = 0; PCSrcE = 0;
        ALUResultE = 0; PrALUResultE = 0; PrPCSrcE = 0;
        #12;
        chk("rst_ClrEn", ClrEn, 1'b1);
        chk("rst_ClrIdx", ClrIdx, 6'd0);
        chk("rst_InitBusy", InitBusy, 1'b1);
        chk("rst_Redirect", Redirect, 1'b0);
        chk("rst_RedirectPC", RedirectPC, 32'd0);
        chk("rst_BranchCnt", BranchCnt, 16'd0);
        @(posedge CLK);
        #1 RESETn = 1;
        sweep_check("sweep");

        drv(1, 0, 32'h0, 1, 32'h100, 0, 32'h0);
        @(negedge CLK);
        chk("dt_BM", BM, 1'b1);
        chk("dt_BTA", BTA, 1'b1);
        chk("dt_Redirect", Redirect, 1'b1);
        chk("dt_RPC", RedirectPC, 32'h100);
        chk("dt_FlushD", FlushD, 1'b1);
        chk("dt_FlushE", FlushE, 1'b1);
        idle();
        @(negedge CLK);
        chk("dt_MissCnt", MissCnt, 16'd1);
        chk("dt_BranchCnt", BranchCnt, 16'd1);

        drv(1, 0, 32'h40, 0, 32'h999, 1, 32'h80);
        @(negedge CLK);
        chk("dn_RPC", RedirectPC, 32'h44);
        chk("dn_BM", BM, 1'b1);
        chk("dn_BTA", BTA, 1'b0);

        drv(1, 0, 32'h80, 1, 32'h300, 1, 32'h200);
        @(negedge CLK);
        chk("tm_BTA", BTA, 1'b1);
        chk("tm_BM", BM, 1'b0);
        chk("tm_Redirect", Redirect, 1'b1);
        chk("tm_RPC", RedirectPC, 32'h300);

        drv(1, 0, 32'h90, 1, 32'h300, 1, 32'h300);
        @(negedge CLK);
        chk("ok_BM", BM, 1'b0);
        chk("ok_BTA", BTA, 1'b0);
        chk("ok_Redirect", Redirect, 1'b0);
        idle();
        @(negedge CLK);
        chk("ok_BranchCnt", BranchCnt, 16'd4);
        chk("ok_MissCnt", MissCnt, 16'd3);

        drv(1, 1, 32'ha0, 1, 32'h500, 0, 32'h0);
        @(negedge CLK);
        chk("st_first_BM", BM, 1'b1);
        chk("st_first_Redirect", Redirect, 1'b1);
        for (int k = 0; k < 2; k++) begin
            drv(1, 1, 32'ha0, 1, 32'h500, 0, 32'h0);
            @(negedge CLK);
            chk("st_held_BM", BM, 1'b0);
            chk("st_held_Redirect", Redirect, 1'b0);
        end
        drv(1, 0, 32'ha0, 1, 32'h500, 0, 32'h0);
        @(negedge CLK);
        chk("st_leave_BM", BM, 1'b0);
        idle();
        @(negedge CLK);
        chk("st_BranchCnt", BranchCnt, 16'd5);
        chk("st_MissCnt", MissCnt, 16'd4);

        @(posedge CLK);
        #1 PredEn = 0; PrPCSrcF_in = 1;
        @(negedge CLK);
        chk("gate_off", PrPCSrcF, 1'b0);
        @(posedge CLK);
        #1 PredEn = 1;
        @(negedge CLK);
        chk("gate_on", PrPCSrcF, 1'b1);

        for (int k = 0; k < 20; k++) begin
            drv(1, 0, 32'h100 + k * 4, 0, 32'h0, 1, 32'h40);
        end
        idle();
        @(negedge CLK);
        chk("sat_MissCnt4", MissCnt4, 4'd15);
        chk("sat_BranchCnt4", BranchCnt4, 4'd15);
        chk("sat_MissCnt16", MissCnt, 16'd24);

        @(posedge CLK);
        #1 RESETn = 0;
        @(posedge CLK);
        #1 RESETn = 1;
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge CLK);
                if (ClrIdx == 6'd20) begin
                    seen = 1;
                    break;
                end
            end
            chk("mid_reached20", {31'd0, seen}, 32'd1);
        end
        #2 RESETn = 0;
        #1;
        chk("mid_ClrIdx0", ClrIdx, 6'd0);
        chk("mid_MissCnt0", MissCnt, 16'd0);
        @(posedge CLK);
        #1 RESETn = 1;
        sweep_check("resweep");

        for (int k = 0; k < 3000; k++) begin
            @(posedge CLK);
            #1;
            if ($urandom_range(0, 499) == 0) RESETn = 0;
            else RESETn = 1;
            PredEn       = ($urandom_range(0, 3) != 0);
            PrPCSrcF_in  = $urandom_range(0, 1);
            BranchE      = $urandom_range(0, 1);
            StallE       = ($urandom_range(0, 9) < 3);
            PCE          = {$urandom_range(0, 255), 2'b00};
            PCSrcE       = $urandom_range(0, 1);
            PrPCSrcE     = $urandom_range(0, 1);
            ALUResultE   = 32'h100 * $urandom_range(1, 3);
            PrALUResultE = 32'h100 * $urandom_range(1, 3);
        end
        idle();
        @(negedge CLK);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
